// File: rtl/ft_pkg.sv
// ft_pkg: constants and state encoding shared by the recovery sequencer and the checkpoint memory
package ft_pkg;
  localparam int unsigned REG_BYTE_STRIDE = 4;
  localparam int unsigned PC_WORD_ADDR = 128;
  localparam logic [31:0] PC_SLOT_BYTE_ADDR = 32'(PC_WORD_ADDR * REG_BYTE_STRIDE);
  typedef enum logic [2:0] {IDLE, HALT, REQ, WAIT, WRITE, DONE, FAIL} rec_state_e;
  function automatic logic [31:0] word_byte_addr(input int unsigned idx);
    return 32'(idx * REG_BYTE_STRIDE);
  endfunction
endpackage

// File: rtl/ft_recovery_ctrl.sv
// ft_recovery_ctrl: halts the core, replays checkpointed registers and PC from memory, then releases it
//   recover_i            start a restore (accepted in IDLE or FAIL)
//   halt_o / halted_i    core freeze request and acknowledge
//   req_o gnt_i rvalid_i addr_o rdata_i err_i   one-outstanding read port to checkpoint memory
//   rf_we_o rf_waddr_o rf_wdata_o               register-file write port
//   pc_we_o pc_o                                 PC load port
//   busy_o done_o fail_o                         status (fail_o sticky until next accepted restore)
module ft_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter bit          SKIP_R0      = 1'b1,
  parameter int unsigned PC_WORD_ADDR = ft_pkg::PC_WORD_ADDR,
  parameter int unsigned TIMEOUT      = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        recover_i,
  output logic        halt_o,
  input  logic        halted_i,
  output logic        req_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  output logic [31:0] addr_o,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        pc_we_o,
  output logic [31:0] pc_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] START_IDX = IW'(SKIP_R0 ? 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);
  localparam logic [31:0] PC_ADDR = word_byte_addr(PC_WORD_ADDR);
  rec_state_e state_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tmo_q;
  logic pc_phase_q, gnt_seen_q;
  logic halt_q, req_q, rf_we_q, pc_we_q, busy_q, done_q, fail_q;
  logic [31:0] addr_q, rf_wdata_q, pc_q;
  logic [4:0] rf_waddr_q;
  logic gnt_ok;
  // a grant in the same cycle as rvalid still counts as granted
  assign gnt_ok = gnt_seen_q | gnt_i;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tmo_q      <= '0;
      pc_phase_q <= 1'b0;
      gnt_seen_q <= 1'b0;
      halt_q     <= 1'b0;
      req_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      pc_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      addr_q     <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pc_q       <= '0;
    end else begin
      // strobes and their payloads are only valid for the cycle they are issued
      req_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      pc_we_q    <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pc_q       <= '0;
      case (state_q)
        IDLE, FAIL: if (recover_i) begin
          state_q    <= HALT;
          halt_q     <= 1'b1;
          busy_q     <= 1'b1;
          fail_q     <= 1'b0;
          idx_q      <= START_IDX;
          pc_phase_q <= 1'b0;
        end
        HALT: if (halted_i) begin
          state_q <= REQ;
          req_q   <= 1'b1;
          addr_q  <= word_byte_addr(32'(idx_q));
        end
        REQ: begin
          state_q    <= WAIT;
          tmo_q      <= '0;
          gnt_seen_q <= gnt_i;
        end
        WAIT: begin
          gnt_seen_q <= gnt_ok;
          tmo_q      <= tmo_q + 1'b1;
          if (rvalid_i && !err_i && gnt_ok) begin
            state_q    <= WRITE;
            rf_we_q    <= !pc_phase_q;
            rf_waddr_q <= pc_phase_q ? 5'd0 : 5'(idx_q);
            rf_wdata_q <= pc_phase_q ? 32'd0 : rdata_i;
            pc_we_q    <= pc_phase_q;
            pc_q       <= pc_phase_q ? rdata_i : 32'd0;
          end else if (rvalid_i || tmo_q == TW'(TIMEOUT - 1)) begin
            // core stays halted so it never runs on a half-restored context
            state_q <= FAIL;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        WRITE: if (pc_phase_q) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else begin
          state_q <= REQ;
          req_q   <= 1'b1;
          if (idx_q == LAST_IDX) begin
            pc_phase_q <= 1'b1;
            addr_q     <= PC_ADDR;
          end else begin
            idx_q  <= idx_q + 1'b1;
            addr_q <= word_byte_addr(32'(idx_q) + 32'd1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          halt_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign halt_o     = halt_q;
  assign req_o      = req_q;
  assign addr_o     = addr_q;
  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign pc_we_o    = pc_we_q;
  assign pc_o       = pc_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign fail_o     = fail_q;
endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// tb_ft_recovery_ctrl: scoreboard bench for the recovery sequencer (SKIP_R0=1 and SKIP_R0=0 instances)
module tb_ft_recovery_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [1:0] recover, halted, stray;
  logic [1:0] halt, req, rf_we, pc_we, busy, done, fail;
  logic [1:0][31:0] addr, rf_wdata, pc;
  logic [1:0][4:0] rf_waddr;
  int err_word[2], drop_word[2];
  typedef struct {int inst; int kind; int idx; logic [31:0] data;} ev_t;
  ev_t exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] mon_ea;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int first_req_cyc = -1, last_req_cyc = -1, last_we_cyc = -1, pc_cyc = 0, done_cyc = 0, fail_cyc = 0;
  logic [1:0] prev_req = '0, prev_fail = '0;
  function automatic logic [31:0] ck(input int w);
    return w == 128 ? 32'h0000_0400 : 32'h1000_0000 + 32'(w);
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic gnt_l = 1'b0, rv_l = 1'b0, err_l = 1'b0;
    logic [31:0] rd_l = '0, a0 = '0, a1 = '0;
    logic [1:0] sh = '0;
    ft_recovery_ctrl #(.NUM_REGS(32), .SKIP_R0(g == 0), .PC_WORD_ADDR(128), .TIMEOUT(8)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .recover_i(recover[g]), .halt_o(halt[g]), .halted_i(halted[g]),
      .req_o(req[g]), .gnt_i(gnt_l), .rvalid_i(rv_l), .addr_o(addr[g]), .rdata_i(rd_l), .err_i(err_l),
      .rf_we_o(rf_we[g]), .rf_waddr_o(rf_waddr[g]), .rf_wdata_o(rf_wdata[g]), .pc_we_o(pc_we[g]),
      .pc_o(pc[g]), .busy_o(busy[g]), .done_o(done[g]), .fail_o(fail[g]));
    // nominal memory: grant one cycle after req, data the cycle after that
    always @(negedge clk) begin
      gnt_l = sh[0];
      rv_l  = (sh[1] && int'(a1 >> 2) != drop_word[g]) || stray[g];
      err_l = sh[1] && int'(a1 >> 2) == err_word[g];
      rd_l  = sh[1] ? ck(int'(a1 >> 2)) : 32'h0;
      sh = {sh[0], req[g]};
      a1 = a0;
      a0 = addr[g];
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic got(input int g, input int k, input int idx, input logic [31:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: got inst%0d kind %0d idx %0d data %h, expected nothing", g, k, idx, d);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != g || e.kind != k || e.idx != idx || e.data !== d) begin
        n_bad++;
        $display("FAIL event: got inst%0d kind %0d idx %0d data %h, expected inst%0d kind %0d idx %0d data %h",
                 g, k, idx, d, e.inst, e.kind, e.idx, e.data);
      end
    end
  endtask
  // kinds: 0 register write, 1 PC load, 2 done, 3 fail rising
  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (req[g]) begin
        n_cmp++;
        if (prev_req[g]) begin
          n_bad++;
          $display("FAIL req_b2b inst%0d: req_o high on consecutive cycles at cycle %0d", g, cyc);
        end else if (addr_q.size() == 0) begin
          n_bad++;
          $display("FAIL req_addr inst%0d: got request to %h, expected none", g, addr[g]);
        end else begin
          mon_ea = addr_q.pop_front();
          if (addr[g] !== mon_ea) begin
            n_bad++;
            $display("FAIL req_addr inst%0d: got %h, expected %h", g, addr[g], mon_ea);
          end
        end
        if (first_req_cyc < 0) first_req_cyc = cyc;
        last_req_cyc = cyc;
      end
      if (rf_we[g] || pc_we[g]) begin
        if (last_we_cyc >= 0) begin
          n_cmp++;
          if (cyc - last_we_cyc != 4) begin
            n_bad++;
            $display("FAIL write_gap inst%0d: got %0d cycles, expected 4", g, cyc - last_we_cyc);
          end
        end
        last_we_cyc = cyc;
      end
      if (rf_we[g]) got(g, 0, int'(rf_waddr[g]), rf_wdata[g]);
      if (pc_we[g]) begin
        got(g, 1, 0, pc[g]);
        pc_cyc = cyc;
      end
      if (done[g]) begin
        got(g, 2, 0, 32'h0);
        done_cyc = cyc;
      end
      if (fail[g] && !prev_fail[g]) begin
        got(g, 3, 0, 32'h0);
        fail_cyc = cyc;
      end
      prev_req[g]  = req[g];
      prev_fail[g] = fail[g];
    end
  end
  // queue the address sequence and events for one restore; word 32 is the PC slot
  task automatic plan(input int g, input int first, input int stop, input bit fails);
    for (int w = first; w <= 32; w++) begin
      addr_q.push_back(w == 32 ? 32'h0000_0200 : 32'(4 * w));
      if (w == stop) begin
        if (fails) exp_q.push_back(ev_t'{g, 3, 0, 32'h0});
        return;
      end
      if (w == 32) exp_q.push_back(ev_t'{g, 1, 0, 32'h0000_0400});
      else exp_q.push_back(ev_t'{g, 0, w, 32'h1000_0000 + 32'(w)});
    end
    exp_q.push_back(ev_t'{g, 2, 0, 32'h0});
  endtask
  task automatic start(input int g);
    first_req_cyc = -1;
    last_we_cyc = -1;
    @(posedge clk); #1 recover[g] = 1'b1;
    @(posedge clk); #1 recover[g] = 1'b0;
    chk("halt_entry", {29'b0, halt[g], busy[g], fail[g]}, 32'b110);
    @(posedge clk); #1 halted[g] = 1'b1;
    repeat (4) @(posedge clk);
    #1 halted[g] = 1'b0;
  endtask
  task automatic wait_for(input int g, input int what, input logic [31:0] a, input int budget, input string nm);
    bit hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      hit = what == 0 ? done[g] : what == 1 ? fail[g] : (req[g] && addr[g] == a);
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no response within %0d cycles", nm, budget);
    end
  endtask
  function automatic logic [31:0] ctl(input int g);
    return {25'b0, halt[g], busy[g], fail[g], req[g], rf_we[g], pc_we[g], done[g]};
  endfunction
  function automatic logic [31:0] dat(input int g);
    return addr[g] | rf_wdata[g] | pc[g] | 32'(rf_waddr[g]);
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    recover = '0;
    halted = '0;
    stray = '0;
    err_word = '{-1, -1};
    drop_word = '{-1, -1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ctl", ctl(g), 32'h0);
      chk("rst_dat", dat(g), 32'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 stray[0] = 1'b1;
    @(posedge clk); #1 stray[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("stray_idle", ctl(0), 32'h0);
    plan(0, 1, -1, 1'b0);
    start(0);
    repeat (20) @(posedge clk);
    #1 recover[0] = 1'b1;
    @(posedge clk); #1 recover[0] = 1'b0;
    wait_for(0, 0, 32'h0, 300, "nominal_done");
    @(negedge clk);
    chk("pc_span", 32'(pc_cyc - first_req_cyc + 1), 32'd128);
    chk("done_lat", 32'(done_cyc - pc_cyc), 32'd1);
    chk("post_done", ctl(0), 32'h0);
    chk("q_nominal", 32'(exp_q.size() + addr_q.size()), 32'd0);
    err_word[0] = 5;
    plan(0, 1, 5, 1'b1);
    start(0);
    wait_for(0, 1, 32'h0, 200, "err_fail");
    @(negedge clk);
    chk("err_state", ctl(0), 32'b1010000);
    repeat (10) @(negedge clk);
    chk("err_hold", ctl(0), 32'b1010000);
    chk("q_err", 32'(exp_q.size() + addr_q.size()), 32'd0);
    err_word[0] = -1;
    plan(0, 1, -1, 1'b0);
    start(0);
    wait_for(0, 0, 32'h0, 300, "rerun_done");
    @(negedge clk);
    chk("rerun_end", ctl(0), 32'h0);
    chk("q_rerun", 32'(exp_q.size() + addr_q.size()), 32'd0);
    drop_word[0] = 10;
    plan(0, 1, 10, 1'b1);
    start(0);
    wait_for(0, 1, 32'h0, 200, "tmo_fail");
    @(negedge clk);
    chk("tmo_lat", 32'(fail_cyc - last_req_cyc - 1), 32'd8);
    chk("tmo_state", ctl(0), 32'b1010000);
    repeat (12) @(negedge clk);
    chk("tmo_hold", ctl(0), 32'b1010000);
    chk("q_tmo", 32'(exp_q.size() + addr_q.size()), 32'd0);
    drop_word[0] = -1;
    plan(0, 1, 12, 1'b0);
    start(0);
    wait_for(0, 2, 32'h0000_0030, 200, "x12_req");
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ctl", ctl(0), 32'h0);
    chk("rst_mid_dat", dat(0), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("after_rst", ctl(0), 32'h0);
    chk("q_rst", 32'(exp_q.size() + addr_q.size()), 32'd0);
    plan(1, 0, -1, 1'b0);
    start(1);
    wait_for(1, 0, 32'h0, 400, "skip0_done");
    @(negedge clk);
    chk("skip0_span", 32'(pc_cyc - first_req_cyc + 1), 32'd132);
    chk("skip0_end", ctl(1), 32'h0);
    chk("q_skip0", 32'(exp_q.size() + addr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
